// File: rtl/attex_bus_pkg.sv
// Shared types and helpers for the SCC68070 system-bus controller.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package attex_bus_pkg;

   localparam int ADDR_BYTE_W = 24;

   typedef enum logic [1:0] {
      IMMEDIATE = 2'd0,
      WAIT_N    = 2'd1,
      EXT_LEVEL = 2'd2,
      EXT_RISE  = 2'd3
   } ack_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2,
      HOLD = 2'd3
   } bus_state_e;

   // A region matches when the masked byte address equals its base.
   function automatic logic region_hit(input logic [ADDR_BYTE_W-1:0] addr_byte,
                                       input logic [ADDR_BYTE_W-1:0] base,
                                       input logic [ADDR_BYTE_W-1:0] mask);
      return (addr_byte & mask) == base;
   endfunction

endpackage

// File: rtl/attex_irq_timer.sv
// Per-channel access-to-interrupt delay counter.
// Latency: irq pulses delay-1 cycles after the load edge; delay 0 never fires.
// Backpressure: none; a new load simply restarts the countdown.
module attex_irq_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_i,
   input  logic [7:0] delay_i,
   output logic       irq_o
);

   logic [7:0] cnt_q;

   // Reload on a new access to this channel, otherwise count down to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else if (load_i && (delay_i != 8'd0)) begin
         cnt_q <= delay_i;
      end else if (cnt_q != 8'd0) begin
         cnt_q <= cnt_q - 8'd1;
      end
   end

   assign irq_o = (cnt_q == 8'd1);

endmodule

// File: rtl/attex_bus_ctrl.sv
// SCC68070 bus controller: address decode, per-channel ack generation, bus error, read mux.
// Latency: cs one cycle after start, bus_ack/bus_err two cycles after start (plus ack-mode wait).
// Backpressure: the CPU holds as/uds/lds until it sees ack or err; HOLD waits for the strobes to drop.
module attex_bus_ctrl
   import attex_bus_pkg::*;
#(
   parameter int                      NUM_CH      = 4,
   parameter int                      DATA_W      = 16,
   parameter int                      TIMEOUT     = 255,
   parameter logic [NUM_CH*24-1:0]    REGION_BASE = {NUM_CH{24'h0}},
   parameter logic [NUM_CH*24-1:0]    REGION_MASK = {NUM_CH{24'hFF0000}},
   parameter logic [NUM_CH*2-1:0]     ACK_MODE    = {NUM_CH{2'd0}},
   parameter logic [NUM_CH*4-1:0]     WAIT_CYC    = {NUM_CH{4'd0}},
   parameter logic [NUM_CH*8-1:0]     IRQ_DELAY   = {NUM_CH{8'd0}}
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [22:0]              addr,
   input  logic                     as,
   input  logic                     uds,
   input  logic                     lds,
   input  logic                     write_strobe,
   input  logic [NUM_CH*DATA_W-1:0] ch_dout,
   input  logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        cs,
   output logic [DATA_W-1:0]        data_in,
   output logic                     bus_ack,
   output logic                     bus_err,
   output logic [NUM_CH-1:0]        irq
);

   localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   bus_state_e               state_q;
   logic [CH_W-1:0]          ch_q;
   logic [3:0]               wait_q;
   logic [7:0]               tmo_q;
   logic [NUM_CH-1:0]        ch_ack_q;
   logic [NUM_CH-1:0]        cs_q;
   logic [DATA_W-1:0]        data_q;
   logic                     bus_ack_q;
   logic                     bus_err_q;

   logic [ADDR_BYTE_W-1:0]   addr_byte;
   logic [NUM_CH-1:0]        hit;
   logic [NUM_CH-1:0]        hit_oh;
   logic                     hit_any;
   logic [CH_W-1:0]          hit_idx;
   logic [3:0]               hit_wait;
   logic                     start;

   ack_mode_e                cur_mode;
   logic [DATA_W-1:0]        cur_dout;
   logic                     cur_ack;
   logic                     cur_ack_prev;
   logic                     ack_ok;

   // The controller itself is direction-agnostic; writes are acked exactly like reads.
   logic                     unused_write;
   assign unused_write = write_strobe;

   assign addr_byte = {addr, 1'b0};
   assign start     = (state_q == IDLE) && as && (uds || lds);

   // Region decode with lowest-index priority; also picks up the winner's wait count.
   always_comb begin
      hit      = '0;
      hit_oh   = '0;
      hit_any  = 1'b0;
      hit_idx  = '0;
      hit_wait = 4'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = region_hit(addr_byte, REGION_BASE[i*24 +: 24], REGION_MASK[i*24 +: 24]);
      end
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_any   = 1'b1;
            hit_idx   = CH_W'(i);
            hit_oh    = '0;
            hit_oh[i] = 1'b1;
            hit_wait  = WAIT_CYC[i*4 +: 4];
         end
      end
   end

   // Per-channel view of the channel latched at start.
   always_comb begin
      cur_mode     = IMMEDIATE;
      cur_dout     = '0;
      cur_ack      = 1'b0;
      cur_ack_prev = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_q == CH_W'(i)) begin
            cur_mode     = ack_mode_e'(ACK_MODE[i*2 +: 2]);
            cur_dout     = ch_dout[i*DATA_W +: DATA_W];
            cur_ack      = ch_ack[i];
            cur_ack_prev = ch_ack_q[i];
         end
      end
   end

   // Ack condition for the current WAIT cycle, by the channel's ack mode.
   always_comb begin
      ack_ok = 1'b0;
      case (cur_mode)
         IMMEDIATE: ack_ok = 1'b1;
         WAIT_N:    ack_ok = (wait_q == 4'd0);
         EXT_LEVEL: ack_ok = cur_ack;
         EXT_RISE:  ack_ok = cur_ack && !cur_ack_prev;
         default:   ack_ok = 1'b0;
      endcase
   end

   // Access state machine with registered cs, read data, ack and error outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         wait_q    <= 4'd0;
         tmo_q     <= 8'd0;
         ch_ack_q  <= '0;
         cs_q      <= '0;
         data_q    <= '0;
         bus_ack_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         // Edge history runs in every state so a rise before WAIT is already consumed.
         ch_ack_q  <= ch_ack;
         bus_ack_q <= 1'b0;
         bus_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cs_q <= '0;
               if (start) begin
                  if (hit_any) begin
                     state_q <= WAIT;
                     ch_q    <= hit_idx;
                     cs_q    <= hit_oh;
                     wait_q  <= hit_wait;
                     tmo_q   <= 8'd0;
                  end else begin
                     state_q <= ERR;
                  end
               end
            end
            WAIT: begin
               if (!as) begin
                  state_q <= IDLE;
                  cs_q    <= '0;
               end else if (ack_ok) begin
                  bus_ack_q <= 1'b1;
                  data_q    <= cur_dout;
                  state_q   <= HOLD;
               end else if (tmo_q == TMO_LAST) begin
                  bus_err_q <= 1'b1;
                  data_q    <= '0;
                  state_q   <= HOLD;
               end else begin
                  if (wait_q != 4'd0) begin
                     wait_q <= wait_q - 4'd1;
                  end
                  if (tmo_q != 8'hFF) begin
                     tmo_q <= tmo_q + 8'd1;
                  end
               end
            end
            ERR: begin
               bus_err_q <= 1'b1;
               data_q    <= '0;
               cs_q      <= '0;
               state_q   <= HOLD;
            end
            HOLD: begin
               if (!as || !(uds || lds)) begin
                  state_q <= IDLE;
                  cs_q    <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_q    <= '0;
            end
         endcase
      end
   end

   // One delay timer per channel, loaded on that channel's IDLE->WAIT transition.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_irq
      attex_irq_timer u_irq_timer (
         .clk     (clk),
         .reset   (reset),
         .load_i  (start && hit_any && hit_oh[c]),
         .delay_i (IRQ_DELAY[c*8 +: 8]),
         .irq_o   (irq[c])
      );
   end

   assign cs      = cs_q;
   assign data_in = data_q;
   assign bus_ack = bus_ack_q;
   assign bus_err = bus_err_q;

endmodule

// File: tb/tb_attex_bus_ctrl.sv
// Directed self-checking bench for attex_bus_ctrl.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the bench holds the strobes until it has seen the response.
module tb_attex_bus_ctrl;

   logic        clk;
   logic        reset;
   logic [22:0] addr;
   logic        as;
   logic        uds;
   logic        lds;
   logic        write_strobe;
   logic [63:0] ch_dout;
   logic [3:0]  ch_ack;
   logic [3:0]  cs;
   logic [15:0] data_in;
   logic        bus_ack;
   logic        bus_err;
   logic [3:0]  irq;

   int n_assert;
   int n_fail;

   // ch0 0x00xxxx EXT_LEVEL, ch1 0x30xxxx IMMEDIATE irq 20, ch2 0x50xxxx WAIT_N 3, ch3 0x60xxxx EXT_RISE
   attex_bus_ctrl #(
      .NUM_CH      (4),
      .DATA_W      (16),
      .TIMEOUT     (255),
      .REGION_BASE ({24'h600000, 24'h500000, 24'h300000, 24'h000000}),
      .REGION_MASK ({4{24'hFF0000}}),
      .ACK_MODE    ({2'd3, 2'd1, 2'd0, 2'd2}),
      .WAIT_CYC    ({4'd0, 4'd3, 4'd0, 4'd0}),
      .IRQ_DELAY   ({8'd0, 8'd0, 8'd20, 8'd0})
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .as           (as),
      .uds          (uds),
      .lds          (lds),
      .write_strobe (write_strobe),
      .ch_dout      (ch_dout),
      .ch_ack       (ch_ack),
      .cs           (cs),
      .data_in      (data_in),
      .bus_ack      (bus_ack),
      .bus_err      (bus_err),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_acc(input logic [23:0] byte_addr);
      addr = byte_addr[23:1];
      as   = 1'b1;
      uds  = 1'b1;
      lds  = 1'b0;
   endtask

   task automatic end_acc();
      as  = 1'b0;
      uds = 1'b0;
      lds = 1'b0;
   endtask

   initial begin
      int first;
      int cnt;
      int errs;
      int other;

      n_assert     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      addr         = '0;
      as           = 1'b0;
      uds          = 1'b0;
      lds          = 1'b0;
      write_strobe = 1'b0;
      ch_dout      = '0;
      ch_ack       = '0;
      repeat (3) tick();

      check("rst_cs", 32'(cs), 32'h0);
      check("rst_data", 32'(data_in), 32'h0);
      check("rst_ack", 32'(bus_ack), 32'h0);
      check("rst_err", 32'(bus_err), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      tick();

      // Immediate read on channel 1
      ch_dout[16 +: 16] = 16'hBEEF;
      start_acc(24'h300010);
      tick();
      check("imm_cs", 32'(cs), 32'h2);
      check("imm_ack_early", 32'(bus_ack), 32'h0);
      tick();
      check("imm_ack", 32'(bus_ack), 32'h1);
      check("imm_data", 32'(data_in), 32'hBEEF);
      check("imm_noerr", 32'(bus_err), 32'h0);
      tick();
      check("imm_ack_once", 32'(bus_ack), 32'h0);
      check("imm_cs_hold", 32'(cs), 32'h2);
      end_acc();
      tick();
      check("imm_cs_drop", 32'(cs), 32'h0);

      // WAIT_N = 3 on channel 2, two back-to-back accesses
      ch_dout[32 +: 16] = 16'h1234;
      start_acc(24'h500020);
      tick();
      check("wn_cs", 32'(cs), 32'h4);
      first = 0;
      cnt   = 0;
      for (int k = 2; k <= 8; k++) begin
         tick();
         if (bus_ack) begin
            if (first == 0) first = k;
            cnt++;
         end
      end
      check("wn_ack_cycle", 32'(first), 32'd5);
      check("wn_ack_count", 32'(cnt), 32'd1);
      check("wn_data", 32'(data_in), 32'h1234);
      end_acc();
      tick();
      ch_dout[32 +: 16] = 16'h5678;
      start_acc(24'h500022);
      first = 0;
      cnt   = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (bus_ack) begin
            if (first == 0) first = k;
            cnt++;
         end
      end
      check("wn2_ack_cycle", 32'(first), 32'd5);
      check("wn2_ack_count", 32'(cnt), 32'd1);
      check("wn2_data", 32'(data_in), 32'h5678);
      end_acc();
      tick();

      // EXT_RISE on channel 3: pre-existing level must not ack
      ch_dout[48 +: 16] = 16'hCAFE;
      ch_ack[3] = 1'b1;
      repeat (2) tick();
      start_acc(24'h600000);
      tick();
      cnt = 0;
      for (int k = 2; k <= 5; k++) begin
         tick();
         if (bus_ack) cnt++;
      end
      ch_ack[3] = 1'b0;
      for (int k = 6; k <= 10; k++) begin
         tick();
         if (bus_ack) cnt++;
      end
      check("rise_no_level_ack", 32'(cnt), 32'd0);
      ch_ack[3] = 1'b1;
      tick();
      check("rise_ack", 32'(bus_ack), 32'h1);
      check("rise_data", 32'(data_in), 32'hCAFE);
      tick();
      check("rise_ack_once", 32'(bus_ack), 32'h0);
      end_acc();
      ch_ack[3] = 1'b0;
      tick();

      // Unmapped access
      start_acc(24'h700000);
      tick();
      check("unm_cs", 32'(cs), 32'h0);
      check("unm_err_early", 32'(bus_err), 32'h0);
      tick();
      check("unm_err", 32'(bus_err), 32'h1);
      check("unm_data", 32'(data_in), 32'h0);
      check("unm_noack", 32'(bus_ack), 32'h0);
      check("unm_cs2", 32'(cs), 32'h0);
      tick();
      check("unm_err_once", 32'(bus_err), 32'h0);
      end_acc();
      tick();

      // Timeout on channel 0 in EXT_LEVEL with ch_ack low
      ch_dout[0 +: 16] = 16'hAAAA;
      start_acc(24'h000100);
      first = 0;
      errs  = 0;
      cnt   = 0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (bus_err) begin
            if (first == 0) first = k;
            errs++;
         end
         if (bus_ack) cnt++;
      end
      check("tmo_err_cycle", 32'(first), 32'd256);
      check("tmo_err_count", 32'(errs), 32'd1);
      check("tmo_no_ack", 32'(cnt), 32'd0);
      check("tmo_cs_hold", 32'(cs), 32'h1);
      end_acc();
      tick();

      // IRQ delay 20 on channel 1: single pulse 19 cycles after load
      ch_dout[16 +: 16] = 16'h1111;
      start_acc(24'h300000);
      first = 0;
      cnt   = 0;
      other = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (irq[1]) begin
            if (first == 0) first = k;
            cnt++;
         end
         if ((irq & 4'b1101) != 4'b0) other++;
      end
      check("irq_cycle", 32'(first), 32'd20);
      check("irq_count", 32'(cnt), 32'd1);
      check("irq_other", 32'(other), 32'd0);
      end_acc();
      tick();

      // Re-access at cycle 10 moves the pulse
      start_acc(24'h300000);
      first = 0;
      cnt   = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (irq[1]) begin
            if (first == 0) first = k;
            cnt++;
         end
         if (k == 8) as = 1'b0;
         if (k == 9) as = 1'b1;
      end
      check("irq_reload_cycle", 32'(first), 32'd29);
      check("irq_reload_count", 32'(cnt), 32'd1);
      end_acc();
      tick();

      // Reset in the middle of a WAIT
      ch_ack[0] = 1'b0;
      start_acc(24'h000200);
      repeat (4) tick();
      check("rstw_cs_before", 32'(cs), 32'h1);
      reset = 1'b1;
      tick();
      check("rstw_cs", 32'(cs), 32'h0);
      check("rstw_data", 32'(data_in), 32'h0);
      check("rstw_ack", 32'(bus_ack), 32'h0);
      check("rstw_err", 32'(bus_err), 32'h0);
      check("rstw_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      end_acc();
      ch_ack[0] = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (bus_ack || bus_err) cnt++;
      end
      check("rstw_quiet", 32'(cnt), 32'd0);
      ch_ack[0] = 1'b0;
      ch_dout[16 +: 16] = 16'h2222;
      start_acc(24'h300000);
      tick();
      check("rstw_idle_cs", 32'(cs), 32'h2);
      tick();
      check("rstw_idle_ack", 32'(bus_ack), 32'h1);
      check("rstw_idle_data", 32'(data_in), 32'h2222);
      end_acc();
      tick();

      // Abort: as drops mid-WAIT
      start_acc(24'h000300);
      repeat (3) tick();
      check("abort_cs_before", 32'(cs), 32'h1);
      end_acc();
      ch_ack[0] = 1'b1;
      tick();
      check("abort_cs", 32'(cs), 32'h0);
      cnt = 0;
      if (bus_ack || bus_err) cnt++;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (bus_ack || bus_err) cnt++;
      end
      check("abort_quiet", 32'(cnt), 32'd0);
      check("abort_data", 32'(data_in), 32'h2222);
      ch_ack[0] = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/attex_bus_ctrl.md
Name: attex_bus_ctrl

Overview:
Parametrised system-bus controller between the SCC68070 bus and NUM_CH peripheral channels (MCD212, CDIC, slave, NVRAM, ...). It does the following:
- decodes the CPU address into one-hot chip selects;
- runs a per-access state machine that generates bus_ack with a per-channel acknowledge mode;
- raises bus_err on unmapped accesses and on timeouts;
- muxes and registers read data;
- produces per-channel delayed access-interrupt pulses.

It replaces the hand-written decode, ack glue and irq-cooldown logic at system level.

Parameters:
- NUM_CH, 4, number of peripheral channels, 1..8.
- DATA_W, 16, CPU data width.
- TIMEOUT, 255, maximum cycles waiting for an ack before bus_err, 2..255.
- REGION_BASE, {NUM_CH{24'h0}}, packed NUM_CH x 24 byte base addresses; channel 0 is in the LSBs.
- REGION_MASK, {NUM_CH{24'hFF0000}}, packed NUM_CH x 24 compare masks.
- ACK_MODE, {NUM_CH{2'd0}}, packed NUM_CH x 2 ack modes: 0 IMMEDIATE, 1 WAIT_N, 2 EXT_LEVEL, 3 EXT_RISE.
- WAIT_CYC, {NUM_CH{4'd0}}, packed NUM_CH x 4 wait count used by WAIT_N.
- IRQ_DELAY, {NUM_CH{8'd0}}, packed NUM_CH x 8 access-to-irq delay; 0 disables the channel's irq.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: reset; synchronous, active-high.
- addr, in, 23: CPU word address [23:1]; byte address is {addr,1'b0}.
- as, in, 1: address strobe, active-high.
- uds, in, 1: upper data strobe, active-high.
- lds, in, 1: lower data strobe, active-high.
- write_strobe, in, 1: 1 = write access; passed through to peripherals.
- ch_dout, in, NUM_CH*DATA_W: per-channel read data.
- ch_ack, in, NUM_CH: per-channel external ack (used by modes 2 and 3).
- cs, out, NUM_CH: one-hot channel select.
- data_in, out, DATA_W: registered read data to the CPU.
- bus_ack, out, 1: one-cycle access acknowledge.
- bus_err, out, 1: one-cycle bus error.
- irq, out, NUM_CH: one-cycle access-interrupt pulses.

Behaviour:
Reset (synchronous, active-high):
- state IDLE;
- cs, data_in, bus_ack, bus_err and irq all 0;
- wait/timeout counters, irq counters and ch_ack edge registers all cleared.

Start and decode:
- An access starts when state is IDLE and as && (uds || lds).
- hit[i] = (({addr,1'b0} & MASK[i]) == BASE[i]).
- The lowest-index hit wins.
- Channel index is latched at start; addr is not re-decoded during the access.

States:
- IDLE
  - start with a hit → WAIT: cs[ch] = 1 from the next cycle; wait counter is loaded.
  - start with no hit → ERR.
- WAIT: the ack condition depends on ACK_MODE[ch].
  - IMMEDIATE: satisfied in the first WAIT cycle. Latency is start edge + 2 cycles to bus_ack high.
  - WAIT_N: satisfied after WAIT_CYC[ch] additional WAIT cycles. WAIT_CYC = 0 behaves as IMMEDIATE.
  - EXT_LEVEL: satisfied while ch_ack[ch] = 1.
  - EXT_RISE: satisfied when ch_ack[ch] && !ch_ack_q[ch]. ch_ack_q is registered every cycle in every state, so an edge that occurred before WAIT does not count.
  - When the condition is met: bus_ack = 1 for exactly one cycle; on the same edge data_in <= ch_dout[ch] (writes also capture; the CPU ignores the value) → HOLD.
  - Timeout counter counts WAIT cycles. On reaching TIMEOUT without an ack: bus_err = 1 for one cycle, data_in <= 0 → HOLD.
  - If ack and timeout coincide, ack wins.
- ERR: bus_err = 1 for one cycle, data_in <= 0, cs stays all-zero → HOLD.
- HOLD: cs held. Exit to IDLE when !as || !(uds || lds); cs = 0 in IDLE. No new access can start in the HOLD-exit cycle.

Abort:
- as falls during WAIT → IDLE next cycle.
- No bus_ack or bus_err is issued and data_in is unchanged.

Invariants:
- bus_ack and bus_err are never high together.
- Each is at most one pulse per access.
- cs is zero or one-hot.

IRQ:
- On the IDLE→WAIT transition for channel c with IRQ_DELAY[c] != 0, load cnt[c] <= IRQ_DELAY[c]. A new access to the same channel reloads the counter.
- Otherwise cnt[c] decrements while nonzero.
- irq[c] = (cnt[c] == 1), combinational from the counter. The pulse therefore occurs IRQ_DELAY-1 cycles after the load edge.
- Channels are independent.

Widths:
- wait counter 4 bits; timeout counter 8 bits, saturating; irq counters 8 bits.

Decomposition:
- Package attex_bus_pkg:
  - ack_mode_e (IMMEDIATE, WAIT_N, EXT_LEVEL, EXT_RISE);
  - bus_state_e (IDLE, WAIT, ERR, HOLD);
  - ADDR_BYTE_W = 24.
- Sub-module attex_irq_timer, instantiated per channel: load, delay[7:0], irq out.

Test Plan:
1. Defaults, BASE[1] = 24'h300000, mode 0. Read at 0x300010 with ch_dout[1] = 16'hBEEF → cs = 4'b0010 one cycle after start; bus_ack one cycle at start + 2; data_in = 16'hBEEF; cs drops the cycle after as falls.
2. Channel 2 in WAIT_N, WAIT_CYC = 3 → bus_ack exactly 3 cycles later than scenario 1. Back-to-back accesses give exactly one ack each.
3. Channel 3 in EXT_RISE; ch_ack[3] held high before start, falls, then rises 10 cycles into WAIT → no ack on the pre-existing level; bus_ack on the cycle after the rise is sampled.
4. Access to unmapped 0x700000 → bus_err one cycle at start + 2; cs = 0; data_in = 0. Channel in EXT_LEVEL with ch_ack held 0 → bus_err after exactly 255 WAIT cycles.
5. IRQ_DELAY[1] = 20; access channel 1 → irq[1] single pulse 19 cycles after the load edge. Re-access at cycle 10 → pulse moves to 19 cycles after the second load.
6. Reset asserted mid-WAIT → all outputs 0 the next cycle, state IDLE, no ack. Also check as dropped mid-WAIT → return to IDLE with no ack and no err.
